// File: rtl/pipeline_pkg.sv
// Shared IF/ID pipeline definitions: default data width, bubble instruction and field grouping.
// Reused by the ID stage so both sides agree on the register layout.
package pipeline_pkg;

  localparam int          DBITS_DEF    = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [DBITS_DEF-1:0] br_base_offset;
    logic [DBITS_DEF-1:0] pc_incremented;
    logic [DBITS_DEF-1:0] inst_word;
    logic                 prediction;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t r_b;
    r_b                = '0;
    r_b.inst_word      = NOP_INST_DEF;
    return r_b;
  endfunction

endpackage

// File: rtl/pipe_dff.sv
// Generic WIDTH-bit flop with asynchronous active-low clear and load enable.
// Latency 1 cycle; i_en low holds the stored value indefinitely.
module pipe_dff #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_pipe_reg.sv
// IF->ID pipeline register: four fields, one shared enable and async active-low clear.
// Latency 1 cycle; IF_wrt_en low stalls (holds). IFREG_FLUSH_EN adds IF_flush to load a NOP bubble.
module if_pipe_reg
  import pipeline_pkg::*;
#(
  parameter int               DBITS    = DBITS_DEF,
  parameter logic [DBITS-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IF_wrt_en,
`ifdef IFREG_FLUSH_EN
  input  logic             IF_flush,
`endif
  input  logic [DBITS-1:0] brBaseOffset,
  input  logic [DBITS-1:0] pcIncremented,
  input  logic [DBITS-1:0] instWord,
  input  logic             prediction,
  output logic [DBITS-1:0] IF_brBaseOffset,
  output logic [DBITS-1:0] IF_pcIncremented,
  output logic [DBITS-1:0] IF_instWord,
  output logic             IF_prediction
);

  logic             w_en;
  logic [DBITS-1:0] w_bbo_d;
  logic [DBITS-1:0] w_pci_d;
  logic [DBITS-1:0] w_inst_d;
  logic             w_pred_d;

`ifdef IFREG_FLUSH_EN
  // Flush forces a load even while stalled so the bubble always lands.
  assign w_en     = IF_wrt_en | IF_flush;
  assign w_bbo_d  = IF_flush ? '0       : brBaseOffset;
  assign w_pci_d  = IF_flush ? '0       : pcIncremented;
  assign w_inst_d = IF_flush ? NOP_INST : instWord;
  assign w_pred_d = IF_flush ? 1'b0     : prediction;
`else
  assign w_en     = IF_wrt_en;
  assign w_bbo_d  = brBaseOffset;
  assign w_pci_d  = pcIncremented;
  assign w_inst_d = instWord;
  assign w_pred_d = prediction;
`endif

  pipe_dff #(.WIDTH(DBITS)) u_bbo (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_en),
    .i_d   (w_bbo_d),
    .o_q   (IF_brBaseOffset)
  );

  pipe_dff #(.WIDTH(DBITS)) u_pci (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_en),
    .i_d   (w_pci_d),
    .o_q   (IF_pcIncremented)
  );

  pipe_dff #(.WIDTH(DBITS)) u_inst (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_en),
    .i_d   (w_inst_d),
    .o_q   (IF_instWord)
  );

  pipe_dff #(.WIDTH(1)) u_pred (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_en),
    .i_d   (w_pred_d),
    .o_q   (IF_prediction)
  );

endmodule

// File: tb/tb_if_pipe_reg.sv
// Directed-vector scoreboard bench for if_pipe_reg; each row is driven just after a rising edge
// and its expected outputs are checked at the following falling edge, before the next load.
module tb_if_pipe_reg;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        IF_wrt_en;
  logic        IF_flush;
  logic [31:0] brBaseOffset;
  logic [31:0] pcIncremented;
  logic [31:0] instWord;
  logic        prediction;
  logic [31:0] IF_brBaseOffset;
  logic [31:0] IF_pcIncremented;
  logic [31:0] IF_instWord;
  logic        IF_prediction;

  typedef struct {
    logic        rst;
    logic        en;
    logic        fl;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] i;
    logic        pr;
    logic [31:0] eb;
    logic [31:0] ep;
    logic [31:0] ei;
    logic        epr;
    int          idx;
  } row_t;

  row_t rows[$];
  row_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  if_pipe_reg #(.DBITS(32), .NOP_INST(TB_NOP)) dut (
    .clk              (clk),
    .reset            (reset),
    .IF_wrt_en        (IF_wrt_en),
`ifdef IFREG_FLUSH_EN
    .IF_flush         (IF_flush),
`endif
    .brBaseOffset     (brBaseOffset),
    .pcIncremented    (pcIncremented),
    .instWord         (instWord),
    .prediction       (prediction),
    .IF_brBaseOffset  (IF_brBaseOffset),
    .IF_pcIncremented (IF_pcIncremented),
    .IF_instWord      (IF_instWord),
    .IF_prediction    (IF_prediction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic en, input logic fl,
                     input logic [31:0] b, input logic [31:0] p, input logic [31:0] i, input logic pr,
                     input logic [31:0] eb, input logic [31:0] ep, input logic [31:0] ei, input logic epr);
    row_t r;
    r.rst = rst; r.en = en; r.fl = fl;
    r.b = b; r.p = p; r.i = i; r.pr = pr;
    r.eb = eb; r.ep = ep; r.ei = ei; r.epr = epr;
    r.idx = rows.size();
    rows.push_back(r);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      row_t e;
      e = sb.pop_front();
      n_vec++;
      if (IF_brBaseOffset !== e.eb || IF_pcIncremented !== e.ep ||
          IF_instWord !== e.ei || IF_prediction !== e.epr) begin
        n_err++;
        $display("FAIL row%0d: got bbo=%h pci=%h inst=%h pred=%b, want bbo=%h pci=%h inst=%h pred=%b",
                 e.idx, IF_brBaseOffset, IF_pcIncremented, IF_instWord, IF_prediction,
                 e.eb, e.ep, e.ei, e.epr);
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b0; IF_wrt_en = 1'b0; IF_flush = 1'b0;
    brBaseOffset = '0; pcIncremented = '0; instWord = '0; prediction = 1'b0;

    //   rst en fl  b             p             i             pr   -> expected mid-cycle outputs
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h1, 32'hFFFF_FFFE, 32'h3, 1);
    add(0, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(0, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 32'h5,        32'h10,       32'hDEAD_BEEF, 0,  32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 32'h5,        32'h10,       32'hDEAD_BEEF, 0,  32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h1, 32'hFFFF_FFFE, 32'h3, 1);
    add(1, 1, 0, 32'h0,        32'h0,        32'h0,        0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    add(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 32'h5,        32'h10,       32'hDEAD_BEEF, 0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    add(0, 0, 0, 32'h5,        32'h10,       32'hDEAD_BEEF, 0,  32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hC3C3_C3C3, 1, 32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1, 32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1);
    add(1, 0, 0, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1);
`ifdef IFREG_FLUSH_EN
    add(1, 0, 1, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999, 1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1);
    add(1, 0, 0, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999, 1, 32'h0, 32'h0, TB_NOP, 0);
    add(1, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, TB_NOP, 0);
    add(0, 1, 1, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(0, 1, 1, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 1, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 0, 32'h1,        32'hFFFF_FFFE, 32'h3,       1,   32'h0, 32'h0, TB_NOP, 0);
`endif

    foreach (rows[k]) begin
      @(posedge clk);
      #2;
      reset         = rows[k].rst;
      IF_wrt_en     = rows[k].en;
      IF_flush      = rows[k].fl;
      brBaseOffset  = rows[k].b;
      pcIncremented = rows[k].p;
      instWord      = rows[k].i;
      prediction    = rows[k].pr;
      sb.push_back(rows[k]);
    end

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_pipe_reg.md
Name: if_pipe_reg

Overview:
- Pipeline register between the instruction-fetch (IF) stage and the decode stage of the 5-stage core.
- Captures four values on the rising clock edge: branch base/offset, incremented PC, fetched instruction word and branch-prediction bit.
- Presents the captured values to decode for one cycle.
- Supports stall (write-enable low holds contents) and asynchronous clear.

Parameters:
- DBITS, 32: data width of the brBaseOffset, pcIncremented and instWord fields.
- NOP_INST, 32'h0000_0000: instruction word loaded on flush. Only used when IFREG_FLUSH_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all outputs.
- IF_wrt_en  input  1  write enable; 1 = load inputs, 0 = hold (stall).
- brBaseOffset  input  DBITS  branch base/offset computed in IF.
- pcIncremented  input  DBITS  PC+4 from IF.
- instWord  input  DBITS  fetched instruction.
- prediction  input  1  branch predicted taken.
- IF_brBaseOffset  output  DBITS  registered brBaseOffset.
- IF_pcIncremented  output  DBITS  registered pcIncremented.
- IF_instWord  output  DBITS  registered instWord.
- IF_prediction  output  1  registered prediction.

Behaviour:
- Reset value: all outputs are 0 whenever reset=0.
  - Takes effect immediately, without waiting for a clock edge.
  - Overrides IF_wrt_en and all data inputs.
- Reset release: reset going 0->1 is asynchronous. The first load happens on the first rising clk edge with reset=1.
- Load: on a rising clk edge with reset=1 and IF_wrt_en=1, every output takes the value its input had just before the edge.
  - Latency is exactly 1 cycle.
  - Fields are copied bit-exact, with no arithmetic or sign handling.
- Stall: on a rising clk edge with reset=1 and IF_wrt_en=0, all four outputs keep their previous values. Stall may last any number of cycles.
- All four fields share one enable and one reset. They are never partially updated.
- Outputs are pure flop outputs, with no combinational path from any input to any output.
- Input changes between clock edges have no effect on the outputs.
- Reset asserted during a stall still clears the outputs. After release, the register holds 0 until the next enabled edge.

Optional Feature:
- Macro IFREG_FLUSH_EN.
- When defined:
  - Adds input port IF_flush (1 bit), listed after IF_wrt_en.
  - On a rising edge with reset=1 and IF_flush=1, the register loads a bubble: IF_instWord=NOP_INST, IF_prediction=0, IF_brBaseOffset=0, IF_pcIncremented=0.
  - Flush takes priority over IF_wrt_en, so it applies even while stalled.
  - reset=0 still takes priority over flush.
- When not defined: no IF_flush port and no bubble logic. Behaviour is exactly as described above.

Decomposition:
- Shared package (pipeline_pkg): DBITS default, NOP_INST constant and a packed struct grouping the four IF/ID fields, for reuse by the ID stage.
- Sub-module: pipe_dff, a generic WIDTH-parameterized flop with async active-low clear and load enable.
  - if_pipe_reg instantiates one pipe_dff per field.
  - Flush muxing, when enabled, sits in front of pipe_dff.

Test Plan:
- Load: reset=1, IF_wrt_en=1, brBaseOffset=1, pcIncremented=32'hFFFF_FFFE, instWord=3, prediction=1, one rising edge -> outputs 1, 32'hFFFF_FFFE, 3, 1.
- Async reset: from the loaded state, drive reset=0 mid-cycle -> all outputs 0 before the next edge; still 0 after an edge with IF_wrt_en=1.
- Stall: reset=1, IF_wrt_en=0, inputs changed to 5, 32'h10, 32'hDEAD_BEEF, 0, two edges -> outputs unchanged from their prior values (0s after reset).
- Resume: IF_wrt_en=1, one edge with inputs 1, 32'hFFFF_FFFE, 3, 1 -> outputs 1, 32'hFFFF_FFFE, 3, 1. No glitch before the edge.
- Width extremes: all-ones then all-zeros on each DBITS field on consecutive enabled edges -> exact bit copies each cycle.
- Flush (IFREG_FLUSH_EN defined): loaded state, IF_flush=1 with IF_wrt_en=0 on an edge -> IF_instWord=NOP_INST and the other outputs 0. With reset=0 and IF_flush=1 -> outputs 0.
